// File: rtl/sp_ram_multibank_wrap_if.sv
// Core-side request/grant/response bus of the banked single-port RAM wrapper.
// Master drives the request fields; slave (the wrapper) returns gnt and the response.
interface sp_ram_multibank_wrap_if #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    req_i;
  logic                    gnt_o;
  logic [ADDR_WIDTH-1:0]   addr_i;
  logic                    we_i;
  logic [DATA_WIDTH/8-1:0] be_i;
  logic [DATA_WIDTH-1:0]   wdata_i;
  logic                    bypass_en_i;
  logic                    rvalid_o;
  logic [DATA_WIDTH-1:0]   rdata_o;

  modport master (
    output req_i,
    output addr_i,
    output we_i,
    output be_i,
    output wdata_i,
    output bypass_en_i,
    input  gnt_o,
    input  rvalid_o,
    input  rdata_o
  );

  modport slave (
    input  req_i,
    input  addr_i,
    input  we_i,
    input  be_i,
    input  wdata_i,
    input  bypass_en_i,
    output gnt_o,
    output rvalid_o,
    output rdata_o
  );
endinterface

// File: rtl/sp_ram_multibank_wrap.sv
// Banked single-port RAM wrapper: byte-enable writes, req/gnt/rvalid handshake, bypass loopback.
// Define SP_RAM_SLEEP_EN to build the per-bank idle sleep/wake FSMs; otherwise gnt follows req.
module sp_ram_multibank_wrap #(
  parameter int unsigned RAM_SIZE        = 32768,
  parameter int unsigned ADDR_WIDTH      = $clog2(RAM_SIZE),
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned NUM_BANKS       = 4,
  parameter int unsigned BANK_INTERLEAVE = 0,
  parameter int unsigned IDLE_CYCLES     = 64,
  parameter int unsigned WAKE_CYCLES     = 2
) (
  input  logic                  clk,
  input  logic                  rstn_i,
  sp_ram_multibank_wrap_if.slave bus,
  output logic [NUM_BANKS-1:0]  bank_sleep_o
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned ByteOff  = (NumBytes > 1) ? $clog2(NumBytes) : 0;
  localparam int unsigned WordBits = ADDR_WIDTH - ByteOff;
  localparam int unsigned NumWords = RAM_SIZE / NumBytes;

  if (DATA_WIDTH % 8 != 0) begin : gen_bad_width
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if ((NUM_BANKS == 0) || ((NUM_BANKS & (NUM_BANKS - 1)) != 0)) begin : gen_bad_banks
    $error("NUM_BANKS must be a power of two");
  end
  if (BANK_INTERLEAVE > 1) begin : gen_bad_interleave
    $error("BANK_INTERLEAVE must be 0 or 1");
  end
  // WAKE_CYCLES only matters when banks can actually go to sleep.
  if ((IDLE_CYCLES != 0) && (WAKE_CYCLES == 0)) begin : gen_bad_wake
    $error("WAKE_CYCLES must be >= 1");
  end

  logic [WordBits-1:0]   word_idx;
  logic                  grant;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] mem [NumWords];

  assign word_idx = bus.addr_i[ADDR_WIDTH-1:ByteOff];

  if (ByteOff > 0) begin : gen_addr_lsb
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.addr_i[ByteOff-1:0];
  end

  // RAM array: contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (grant && bus.we_i && !bus.bypass_en_i) begin
      for (int i = 0; i < int'(NumBytes); i++) begin
        if (bus.be_i[i]) begin
          mem[word_idx][i*8 +: 8] <= bus.wdata_i[i*8 +: 8];
        end
      end
    end
  end

  // Response stage: one cycle after grant; rdata holds when nothing new is returned.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= grant;
      if (grant && bus.bypass_en_i) begin
        rdata_q <= bus.wdata_i;
      end else if (grant && !bus.we_i) begin
        rdata_q <= mem[word_idx];
      end
    end
  end

  assign bus.gnt_o    = grant;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;

`ifdef SP_RAM_SLEEP_EN
  localparam int unsigned BankBits = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  typedef enum logic [1:0] {StAwake, StSleep, StWake} bank_state_e;

  logic [BankBits-1:0]  bank_sel;
  logic [NUM_BANKS-1:0] bank_awake;

  if (NUM_BANKS == 1) begin : gen_sel_single
    assign bank_sel = '0;
  end else if (BANK_INTERLEAVE == 0) begin : gen_sel_block
    assign bank_sel = word_idx[WordBits-1 -: BankBits];
  end else begin : gen_sel_interleave
    assign bank_sel = word_idx[BankBits-1:0];
  end

  if (IDLE_CYCLES == 0) begin : gen_no_sleep
    logic unused_bank_sel;
    assign unused_bank_sel = ^bank_sel;
    assign bank_awake      = '1;
    assign bank_sleep_o    = '0;
    assign grant           = bus.req_i;
  end else begin : gen_sleep
    localparam int unsigned IdleW = $clog2(IDLE_CYCLES + 1);
    localparam int unsigned WakeW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES + 1) : 1;

    for (genvar b = 0; b < int'(NUM_BANKS); b++) begin : gen_bank
      bank_state_e      state_q;
      logic [IdleW-1:0] idle_q;
      logic [WakeW-1:0] wake_q;
      logic             hit;
      logic             sleep_q;

      // hit in StAwake is exactly a grant to this bank.
      assign hit = bus.req_i && (bank_sel == BankBits'(b));

      always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
          state_q <= StAwake;
          idle_q  <= '0;
          wake_q  <= '0;
          sleep_q <= 1'b0;
        end else begin
          unique case (state_q)
            StAwake: begin
              if (hit) begin
                idle_q <= '0;
              end else if (idle_q == IdleW'(IDLE_CYCLES - 1)) begin
                state_q <= StSleep;
                sleep_q <= 1'b1;
                idle_q  <= '0;
              end else if (idle_q != IdleW'(IDLE_CYCLES)) begin
                idle_q <= idle_q + 1'b1;
              end
            end
            StSleep: begin
              if (hit) begin
                sleep_q <= 1'b0;
                // The SLEEP exit cycle is the first of the WAKE_CYCLES stall cycles.
                if (WAKE_CYCLES <= 1) begin
                  state_q <= StAwake;
                end else begin
                  state_q <= StWake;
                  wake_q  <= WakeW'(1);
                end
              end
            end
            StWake: begin
              if (wake_q >= WakeW'(WAKE_CYCLES - 1)) begin
                state_q <= StAwake;
                wake_q  <= '0;
                idle_q  <= '0;
              end else begin
                wake_q <= wake_q + 1'b1;
              end
            end
            default: begin
              state_q <= StAwake;
              sleep_q <= 1'b0;
              idle_q  <= '0;
              wake_q  <= '0;
            end
          endcase
        end
      end

      assign bank_awake[b]   = (state_q == StAwake);
      assign bank_sleep_o[b] = sleep_q;
    end

    assign grant = bus.req_i && bank_awake[bank_sel];
  end
`else
  assign grant        = bus.req_i;
  assign bank_sleep_o = '0;
`endif

endmodule

// File: tb/tb_sp_ram_multibank_wrap.sv
// Self-checking bench for sp_ram_multibank_wrap: vector table plus scoreboarded responses.
// Sleep/wake sequences run only when SP_RAM_SLEEP_EN is defined.
module tb_sp_ram_multibank_wrap;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] bank_sleep;

  always #5 clk = ~clk;

  sp_ram_multibank_wrap_if #(.ADDR_WIDTH(15), .DATA_WIDTH(32)) bus ();

  sp_ram_multibank_wrap #(
    .RAM_SIZE       (32768),
    .DATA_WIDTH     (32),
    .NUM_BANKS      (4),
    .BANK_INTERLEAVE(1),
    .IDLE_CYCLES    (64),
    .WAKE_CYCLES    (2)
  ) u_dut (
    .clk         (clk),
    .rstn_i      (rstn),
    .bus         (bus),
    .bank_sleep_o(bank_sleep)
  );

  typedef struct {
    logic        we;
    logic [14:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        byp;
    logic [31:0] exp_rdata;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic        exp_rv = 1'b0;
  int          stalls;
  vec_t        vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req_i       = 1'b0;
    bus.we_i        = 1'b0;
    bus.be_i        = 4'h0;
    bus.wdata_i     = 32'h0;
    bus.addr_i      = 15'h0;
    bus.bypass_en_i = 1'b0;
  endtask

  // Advance from one negedge to the next and check the response stage.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check("rvalid", 32'(bus.rvalid_o), 32'(exp_rv));
    if (bus.rvalid_o && exp_q.size() != 0) begin
      check("rdata", bus.rdata_o, exp_q.pop_front());
    end
    exp_rv = 1'b0;
  endtask

  // Called at a negedge; holds the request until granted (bounded), returns at a negedge.
  task automatic access(input logic we, input logic [14:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input logic byp, input logic [31:0] exp_rd,
                        output int n_stall);
    bus.req_i       = 1'b1;
    bus.we_i        = we;
    bus.addr_i      = addr;
    bus.be_i        = be;
    bus.wdata_i     = wd;
    bus.bypass_en_i = byp;
    n_stall         = 0;
    #1;
    while (!bus.gnt_o && n_stall < 20) begin
      tick();
      #1;
      n_stall++;
    end
    check("gnt", 32'(bus.gnt_o), 32'd1);
    if (bus.gnt_o) begin
      exp_q.push_back(exp_rd);
      exp_rv = 1'b1;
    end
    tick();
  endtask

  initial begin
    vecs[0]  = '{1'b1, 15'h0040, 4'hF, 32'hDEADBEEF, 1'b0, 32'h00000000};
    vecs[1]  = '{1'b0, 15'h0040, 4'h0, 32'h00000000, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 15'h0100, 4'hF, 32'h11223344, 1'b0, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 15'h0100, 4'h5, 32'hAABBCCDD, 1'b0, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 15'h0100, 4'h0, 32'h00000000, 1'b0, 32'h11BB33DD};
    vecs[5]  = '{1'b1, 15'h0040, 4'hF, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D};
    vecs[6]  = '{1'b0, 15'h0040, 4'h0, 32'h00000000, 1'b0, 32'hDEADBEEF};
    vecs[7]  = '{1'b0, 15'h0100, 4'h0, 32'h12345678, 1'b1, 32'h12345678};
    vecs[8]  = '{1'b1, 15'h7FFC, 4'hF, 32'hA5A5A5A5, 1'b0, 32'h12345678};
    vecs[9]  = '{1'b1, 15'h0102, 4'h8, 32'h77000000, 1'b0, 32'h12345678};
    vecs[10] = '{1'b0, 15'h7FFF, 4'h0, 32'h00000000, 1'b0, 32'hA5A5A5A5};
    vecs[11] = '{1'b0, 15'h0101, 4'h0, 32'h00000000, 1'b0, 32'h77BB33DD};
    vecs[12] = '{1'b1, 15'h0040, 4'h0, 32'hFFFFFFFF, 1'b0, 32'h77BB33DD};
    vecs[13] = '{1'b0, 15'h0040, 4'h0, 32'h00000000, 1'b0, 32'hDEADBEEF};

    idle_inputs();
    rstn = 1'b0;
    #12;
    check("rst_gnt", 32'(bus.gnt_o), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid_o), 32'd0);
    check("rst_rdata", bus.rdata_o, 32'd0);
    check("rst_sleep", 32'(bank_sleep), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Back-to-back table: every access should be granted without a stall.
    for (int i = 0; i < 14; i++) begin
      access(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].byp,
             vecs[i].exp_rdata, stalls);
      check("no_stall_vec", 32'(stalls), 32'd0);
    end

    // Interleaved stream: one word per bank, back-to-back reads.
    for (int i = 0; i < 4; i++) begin
      access(1'b1, 15'(i * 4), 4'hF, 32'h11111111 * (i + 1), 1'b0, 32'hDEADBEEF, stalls);
    end
    for (int i = 0; i < 4; i++) begin
      access(1'b0, 15'(i * 4), 4'h0, 32'h0, 1'b0, 32'h11111111 * (i + 1), stalls);
      check("stream_stall", 32'(stalls), 32'd0);
    end
    idle_inputs();

`ifdef SP_RAM_SLEEP_EN
    for (int i = 0; i < 10; i++) tick();
    check("not_yet_asleep", 32'(bank_sleep), 32'h0);
    for (int i = 0; i < 60; i++) tick();
    check("all_asleep", 32'(bank_sleep), 32'hF);
    access(1'b0, 15'h0040, 4'h0, 32'h0, 1'b0, 32'hDEADBEEF, stalls);
    idle_inputs();
    check("wake_stalls", 32'(stalls), 32'd2);
    check("others_asleep", 32'(bank_sleep), 32'hE);

    // Reset while bank 1 is waking.
    for (int i = 0; i < 70; i++) tick();
    bus.req_i  = 1'b1;
    bus.addr_i = 15'h0044;
    #1;
    check("sleep_exit_gnt", 32'(bus.gnt_o), 32'd0);
    tick();
    #1;
    check("wake_gnt", 32'(bus.gnt_o), 32'd0);
    check("wake_sleep_bit", 32'(bank_sleep), 32'hD);
    rstn = 1'b0;
    idle_inputs();
    #1;
    check("wrst_gnt", 32'(bus.gnt_o), 32'd0);
    check("wrst_rvalid", 32'(bus.rvalid_o), 32'd0);
    check("wrst_sleep", 32'(bank_sleep), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
`endif

    // Reset in the response cycle: the in-flight read is dropped.
    bus.req_i  = 1'b1;
    bus.addr_i = 15'h0040;
    #1;
    check("pre_rst_gnt", 32'(bus.gnt_o), 32'd1);
    @(posedge clk);
    #1;
    idle_inputs();
    check("pre_rst_rvalid", 32'(bus.rvalid_o), 32'd1);
    rstn = 1'b0;
    #1;
    check("grst_rvalid", 32'(bus.rvalid_o), 32'd0);
    check("grst_gnt", 32'(bus.gnt_o), 32'd0);
    check("grst_rdata", bus.rdata_o, 32'd0);
    check("grst_sleep", 32'(bank_sleep), 32'd0);
    exp_q.delete();
    exp_rv = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    access(1'b0, 15'h0040, 4'h0, 32'h0, 1'b0, 32'hDEADBEEF, stalls);
    access(1'b0, 15'h0008, 4'h0, 32'h0, 1'b0, 32'h33333333, stalls);
    idle_inputs();
    tick();
    check("rdata_hold", bus.rdata_o, 32'h33333333);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
